prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12: memory word-address width.
REQ-002 Parameter TEXT_BASE, default 0: word address of the first .text word.
REQ-003 Parameter DATA_BASE, default 2048: word address of the first .data word.
REQ-004 Parameter MAX_WORDS, default 2048: maximum number of words per segment.
REQ-005 Parameter HOLD_CYCLES, default 4: number of cycles cpu_reset stays high after loading completes.
REQ-006 Port clk  in  1: single clock; all state changes on the rising edge.
REQ-007 Port reset  in  1: asynchronous, active-low reset.
REQ-008 Port start  in  1: single-cycle request to begin a load.
REQ-009 Port load_data  in  1: sampled with start; 1 means a .data segment follows the .text segment.
REQ-010 Port in_valid  in  1: the source presents a word.
REQ-011 Port in_data  in  32: the image word.
REQ-012 Port in_last  in  1: marks the final word of the current segment.
REQ-013 Port in_ready  out  1: the loader accepts a word; a beat transfers when in_valid and in_ready are both high on a clock edge.
REQ-014 Port mem_we  out  1: write strobe to the unified memory.
REQ-015 Port mem_addr  out  ADDR_W: memory word address.
REQ-016 Port mem_wdata  out  32: memory write data.
REQ-017 Port cpu_reset  out  1: active-high reset driven to the CPU.
REQ-018 Port busy  out  1: high while any load state is active.
REQ-019 Port done  out  1: high in RUN.
REQ-020 Port error  out  1: high in ERROR.
REQ-021 Port word_count  out  ADDR_W+1: words accepted in the current segment.

Function
REQ-022 The state machine SHALL have the states IDLE, LOAD_TEXT, LOAD_DATA, CHECK, HOLD, RUN and ERROR.
REQ-023 IDLE: on start, move to LOAD_TEXT, latch load_data, clear word_count, and hold cpu_reset high.
REQ-024 in_ready SHALL be high only in LOAD_TEXT, LOAD_DATA and CHECK.
REQ-025 Write latency: a beat accepted at edge k SHALL drive mem_we=1 during cycle k+1, with mem_addr = base + word_count(before the beat) and mem_wdata = in_data; mem_we SHALL be 0 in every other cycle.
REQ-026 The base address SHALL be TEXT_BASE in LOAD_TEXT and DATA_BASE in LOAD_DATA; addresses wrap modulo 2^ADDR_W.
REQ-027 A beat with in_last in LOAD_TEXT SHALL go to LOAD_DATA if load_data was latched high, else to CHECK (macro defined) or HOLD (macro undefined); word_count SHALL clear on any segment change.
REQ-028 A beat with in_last in LOAD_DATA SHALL go to CHECK (macro defined) or HOLD (macro undefined).
REQ-029 Overflow: a beat without in_last accepted when word_count = MAX_WORDS-1 SHALL be written and SHALL then move to ERROR.
REQ-030 HOLD SHALL keep cpu_reset high for exactly HOLD_CYCLES cycles and then enter RUN.
REQ-031 RUN SHALL drive cpu_reset=0 and done=1.
REQ-032 Restart: start in RUN or ERROR SHALL behave as start in IDLE, and cpu_reset SHALL reassert on the next edge.
REQ-033 start SHALL be ignored in LOAD_TEXT, LOAD_DATA, CHECK and HOLD.
REQ-034 cpu_reset SHALL be high in every state except RUN, including ERROR.

Reset
REQ-035 Asserting reset low SHALL immediately, regardless of the clock, force: state IDLE, cpu_reset=1, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, error=0, word_count=0, checksum=0.
REQ-036 Reset asserted mid-load SHALL abort the load with no further mem_we pulses; a new start is required after reset deasserts.

Configuration
REQ-037 Macro LOADER_CHECKSUM_EN defined: a 32-bit wrapping sum of all accepted image words SHALL be accumulated; CHECK accepts one further word, which SHALL not be written to memory; equal to the sum -> HOLD, unequal -> ERROR.
REQ-038 Macro LOADER_CHECKSUM_EN undefined: there is no CHECK state, no accumulator and no extra beat.

Verification
REQ-039 Text-only load: start with load_data=0, then 3 words 0x20080005, 0x20090007, 0x01095020 (last on the third) -> mem_we pulses at addresses 0, 1, 2; after 4 hold cycles cpu_reset falls and done=1.
REQ-040 Text plus data: start with load_data=1, 2 text words, then 2 data words 0x16D and 0x10 -> data written at addresses 2048 and 2049; word_count reads 1 after the first data beat.
REQ-041 Backpressure: toggle in_valid every cycle -> no word is dropped or duplicated and addresses stay contiguous.
REQ-042 Overflow with MAX_WORDS=4: 5 words with no in_last -> 4 writes, error=1, cpu_reset stays 1; a subsequent start recovers.
REQ-043 Checksum (macro defined): words 1, 2, 3, then check word 6 -> RUN; the same words with check word 7 -> ERROR, and the check word never drives mem_we.
REQ-044 Reset mid-load: assert reset low after the second beat -> all outputs return to reset values asynchronously and no further writes occur.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: streams a .text (and optionally .data) image into unified memory
// while holding the CPU in reset. Optional checksum verification via LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W      = 12,
  parameter int TEXT_BASE   = 0,
  parameter int DATA_BASE   = 2048,
  parameter int MAX_WORDS   = 2048,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_data,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TEXT,
    LOAD_DATA,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    HOLD,
    RUN,
    ERROR
  } state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_LAST  = (ADDR_W+1)'(MAX_WORDS - 1);
  localparam logic [ADDR_W-1:0] TEXT_ADDR = ADDR_W'(TEXT_BASE);
  localparam logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(DATA_BASE);

  state_t            state_q, state_d;
  logic              load_data_q, load_data_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q, checksum_d;
`endif

  logic              beat;
  logic [ADDR_W-1:0] seg_base;
  state_t            after_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      load_data_q  <= 1'b0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      hold_cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      hold_cnt_q   <= hold_cnt_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      LOAD_TEXT, LOAD_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      HOLD:    busy = 1'b1;
      default: ;
    endcase
  end

  assign beat       = in_valid && in_ready;
  assign seg_base   = (state_q == LOAD_DATA) ? DATA_ADDR : TEXT_ADDR;
`ifdef LOADER_CHECKSUM_EN
  assign after_load = CHECK;
`else
  assign after_load = HOLD;
`endif

  always_comb begin
    state_d      = state_q;
    load_data_d  = load_data_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    hold_cnt_d   = hold_cnt_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (start) begin
          state_d      = LOAD_TEXT;
          load_data_d  = load_data;
          word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      LOAD_TEXT, LOAD_DATA: begin
        if (beat) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = seg_base + word_count_q[ADDR_W-1:0];
          mem_wdata_d  = in_data;
          word_count_d = word_count_q + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          checksum_d   = checksum_q + in_data;
`endif
          if (in_last) begin
            word_count_d = '0;
            hold_cnt_d   = '0;
            if (state_q == LOAD_TEXT && load_data_q) state_d = LOAD_DATA;
            else                                     state_d = after_load;
          end else if (word_count_q == MAX_LAST) begin
            state_d = ERROR;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // The check word is compared but never written to memory.
      CHECK: begin
        if (beat) begin
          hold_cnt_d = '0;
          state_d    = (in_data == checksum_q) ? HOLD : ERROR;
        end
      end
`endif
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign cpu_reset  = (state_q != RUN);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed loads push expected memory writes,
// a negedge monitor pops and compares each mem_we pulse.
module tb_prog_loader;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              reset;
  logic              start;
  logic              load_data;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  fails;

  prog_loader #(
    .ADDR_W(ADDR_W), .TEXT_BASE(0), .DATA_BASE(2048), .MAX_WORDS(4), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .load_data(load_data),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check_output("write_addr", 32'(mem_addr), 32'(e.addr));
          check_output("write_data", mem_wdata, e.data);
        end
      end
    end
  end

  task automatic do_start(input logic ld);
    start     = 1'b1;
    load_data = ld;
    @(posedge clk); #1;
    start     = 1'b0;
    load_data = 1'b0;
  endtask

  task automatic apply_beat(input logic [31:0] d, input logic last, input bit push,
                            input logic [ADDR_W-1:0] addr, input int budget, output bit accepted);
    wr_t e;
    accepted = 1'b0;
    if (push) begin
      e.addr = addr;
      e.data = d;
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk); #1;
      if (accepted) break;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [ADDR_W-1:0] addr);
    bit acc;
    apply_beat(d, last, 1'b1, addr, 10, acc);
    check_output("beat_accepted", 32'(acc), 32'd1);
  endtask

  task automatic finish_load(input logic [31:0] sum);
    int  hold;
    bit  acc;
    hold = 0;
`ifdef LOADER_CHECKSUM_EN
    apply_beat(sum, 1'b1, 1'b0, '0, 10, acc);
    check_output("check_beat_accepted", 32'(acc), 32'd1);
`else
    acc = (sum == 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (cpu_reset) hold++;
    end
    @(posedge clk); #1;
    check_output("hold_cycles", 32'(hold), 32'd4);
    check_output("run_done", 32'(done), 32'd1);
    check_output("run_cpu_reset", 32'(cpu_reset), 32'd0);
    check_output("run_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
    check_output({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    bit acc;
    checks    = 0;
    fails     = 0;
    reset     = 1'b0;
    start     = 1'b0;
    load_data = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;

    #2;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] text-only load");
    do_start(1'b0);
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_cpu_reset", 32'(cpu_reset), 32'd1);
    beat(32'h2008_0005, 1'b0, 12'd0);
    beat(32'h2009_0007, 1'b0, 12'd1);
    beat(32'h0109_5020, 1'b1, 12'd2);
    finish_load(32'h411A_502C);

    $display("[TB] text plus data load, restart from RUN");
    do_start(1'b1);
    check_output("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("restart_done", 32'(done), 32'd0);
    beat(32'h0000_0001, 1'b0, 12'd0);
    check_output("text_word_count", 32'(word_count), 32'd1);
    beat(32'h0000_0002, 1'b1, 12'd1);
    check_output("seg_change_word_count", 32'(word_count), 32'd0);
    beat(32'h0000_016D, 1'b0, 12'd2048);
    check_output("data_word_count", 32'(word_count), 32'd1);
    beat(32'h0000_0010, 1'b1, 12'd2049);
    finish_load(32'h0000_0180);

    $display("[TB] backpressure load");
    do_start(1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      beat(32'h0000_00A0 + 32'(i), (i == 3), 12'(i));
    end
    finish_load(32'h0000_0286);

    $display("[TB] overflow");
    do_start(1'b0);
    for (int i = 0; i < 4; i++) beat(32'h0000_0B00 + 32'(i), 1'b0, 12'(i));
    apply_beat(32'h0000_0B04, 1'b0, 1'b0, '0, 4, acc);
    check_output("overflow_fifth_refused", 32'(acc), 32'd0);
    check_output("overflow_error", 32'(error), 32'd1);
    check_output("overflow_cpu_reset", 32'(cpu_reset), 32'd1);
    check_output("overflow_busy", 32'(busy), 32'd0);
    do_start(1'b0);
    check_output("recover_error", 32'(error), 32'd0);
    beat(32'h0000_0055, 1'b1, 12'd0);
    finish_load(32'h0000_0055);

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum match and mismatch");
    do_start(1'b0);
    beat(32'd1, 1'b0, 12'd0);
    beat(32'd2, 1'b0, 12'd1);
    beat(32'd3, 1'b1, 12'd2);
    finish_load(32'd6);
    do_start(1'b0);
    beat(32'd1, 1'b0, 12'd0);
    beat(32'd2, 1'b0, 12'd1);
    beat(32'd3, 1'b1, 12'd2);
    apply_beat(32'd7, 1'b1, 1'b0, '0, 10, acc);
    check_output("bad_check_accepted", 32'(acc), 32'd1);
    check_output("bad_check_error", 32'(error), 32'd1);
    check_output("bad_check_cpu_reset", 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
`endif

    $display("[TB] reset mid-load");
    do_start(1'b1);
    beat(32'h0000_0C01, 1'b0, 12'd0);
    apply_beat(32'h0000_0C02, 1'b0, 1'b0, '0, 10, acc);
    reset = 1'b0;
    #1;
    check_reset_outputs("midload");
    @(posedge clk); @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h0000_0C03;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check_output("post_reset_in_ready", 32'(in_ready), 32'd0);
    check_output("post_reset_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
